// File: rtl/sub_32bit.sv
// sub_32bit: registered ripple-chain subtractor a - b; flag logic compiled in with `define SUB_FLAGS_EN
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module twos_complement #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_in,
  output logic [WIDTH-1:0] o_out
);
  assign o_out = ~i_in + WIDTH'(1);
endmodule

module sub_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);
  logic [WIDTH-1:0] w_nb;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_c;
  logic             r_valid;
  logic [WIDTH-1:0] r_diff;

  twos_complement #(.WIDTH(WIDTH)) u_neg (.i_in(b), .o_out(w_nb));

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_fa
      full_adder u_fa (
        .i_a(a[i]),
        .i_b(w_nb[i]),
        .i_c(i == 0 ? 1'b0 : w_c[i == 0 ? 0 : i-1]),
        .o_s(w_sum[i]),
        .o_c(w_c[i])
      );
    end
  endgenerate

  // result register: capture on in_valid, out_valid pulses one cycle per capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_diff  <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) r_diff <= w_sum;
    end
  end

  assign out_valid = r_valid;
  assign diff      = r_diff;

`ifdef SUB_FLAGS_EN
  logic w_borrow;
  logic w_overflow;
  logic r_borrow;
  logic r_overflow;
  logic r_zero;
  logic r_negative;

  // b == 0 negates to 0 with no carry out, so the raw ~c31 would wrongly signal a borrow
  assign w_borrow   = ~w_c[WIDTH-1] & (|b);
  assign w_overflow = (a[WIDTH-1] ^ b[WIDTH-1]) & (w_sum[WIDTH-1] ^ a[WIDTH-1]);

  // flag registers follow the same capture/hold rule as diff
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_borrow   <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
    end else if (in_valid) begin
      r_borrow   <= w_borrow;
      r_overflow <= w_overflow;
      r_zero     <= ~(|w_sum);
      r_negative <= w_sum[WIDTH-1];
    end
  end

  assign borrow   = r_borrow;
  assign overflow = r_overflow;
  assign zero     = r_zero;
  assign negative = r_negative;
`else
  logic w_unused;

  assign w_unused = w_c[WIDTH-1];
  assign borrow   = 1'b0;
  assign overflow = 1'b0;
  assign zero     = 1'b0;
  assign negative = 1'b0;
`endif
endmodule

// File: tb/tb_sub_32bit.sv
// tb_sub_32bit: randomized and directed checks of sub_32bit against an arithmetic reference model
module tb_sub_32bit;
`ifdef SUB_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic [31:0] diff;
  logic        borrow;
  logic        overflow;
  logic        zero;
  logic        negative;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_v;
  logic [36:0] got;

  sub_32bit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid), .diff(diff), .borrow(borrow),
    .overflow(overflow), .zero(zero), .negative(negative)
  );

  always #5 clk = ~clk;

  assign got = {out_valid, diff, borrow, overflow, zero, negative};

  function automatic logic [36:0] model(input logic [31:0] x, input logic [31:0] y);
    longint s;
    logic [31:0] d;
    logic bo, ov, z, n;
    d  = x - y;
    s  = longint'($signed(x)) - longint'($signed(y));
    bo = x < y;
    ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    z  = d == 32'd0;
    n  = d >= 32'h8000_0000;
    return {1'b1, d, FL & bo, FL & ov, FL & z, FL & n};
  endfunction

  task automatic step(input logic [31:0] x, input logic [31:0] y, input logic v);
    @(negedge clk);
    a = x;
    b = y;
    in_valid = v;
    @(posedge clk);
    #1;
    if (v) exp_v = model(x, y);
    else exp_v[36] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b1;
    a = $urandom;
    b = $urandom;
    #2;
    checks++;
    if (got !== 37'd0) begin
      errors++;
      $display("FAIL reset_async got=%h exp=%h", got, 37'd0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (got !== 37'd0) begin
      errors++;
      $display("FAIL reset_held got=%h exp=%h", got, 37'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    step(32'd1, 32'd0, 1'b1);
    checks++;
    if (got !== {1'b1, 32'h1, 4'b0000}) begin
      errors++;
      $display("FAIL first_capture got=%h exp=%h", got, {1'b1, 32'h1, 4'b0000});
    end
  endtask

  task automatic test_directed;
    logic [31:0] ta [6];
    logic [31:0] tb [6];
    logic [31:0] td [6];
    logic [3:0]  tf [6];
    ta = '{32'hFFFF_FFFF, 32'h0, 32'h0,         32'hAAAA_AAAA, 32'h8000_0000, 32'h7FFF_FFFF};
    tb = '{32'hFFFF_FFFF, 32'h0, 32'h1,         32'h5555_5555, 32'h1,         32'hFFFF_FFFF};
    td = '{32'h0,         32'h0, 32'hFFFF_FFFF, 32'h5555_5555, 32'h7FFF_FFFF, 32'h8000_0000};
    tf = '{4'b0010,       4'b0010, 4'b1001,     4'b0100,       4'b0100,       4'b1101};
    for (int k = 0; k < 6; k++) begin
      step(ta[k], tb[k], 1'b1);
      checks++;
      if (got !== {1'b1, td[k], tf[k] & {4{FL}}}) begin
        errors++;
        $display("FAIL directed_%0d got=%h exp=%h", k, got, {1'b1, td[k], tf[k] & {4{FL}}});
      end
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL directed_model_%0d got=%h exp=%h", k, got, exp_v);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] x, y;
    logic v;
    for (int k = 0; k < 300; k++) begin
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 7) == 0) y = x;
      if ($urandom_range(0, 7) == 0) y = 32'd0;
      if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
      v = $urandom_range(0, 3) != 0;
      step(x, y, v);
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL random_%0d a=%h b=%h v=%0d got=%h exp=%h", k, x, y, v, got, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] x, y;
    for (int k = 0; k < 4; k++) begin
      x = $urandom;
      y = $urandom;
      step(x, y, 1'b1);
      checks++;
      if (got !== model(x, y)) begin
        errors++;
        $display("FAIL b2b_%0d got=%h exp=%h", k, got, model(x, y));
      end
    end
  endtask

  task automatic test_hold;
    logic [35:0] held;
    step(32'd0, 32'd1, 1'b1);
    held = exp_v[35:0];
    for (int k = 0; k < 2; k++) begin
      step($urandom, $urandom, 1'b0);
      checks++;
      if (got !== {1'b0, held}) begin
        errors++;
        $display("FAIL hold_%0d got=%h exp=%h", k, got, {1'b0, held});
      end
    end
  endtask

  task automatic test_reset_mid;
    step(32'h1234_5678, 32'h0000_0001, 1'b1);
    @(negedge clk);
    a = 32'h9999_9999;
    b = 32'h1;
    in_valid = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (got !== 37'd0) begin
      errors++;
      $display("FAIL reset_mid got=%h exp=%h", got, 37'd0);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (got !== 37'd0) begin
      errors++;
      $display("FAIL reset_discard got=%h exp=%h", got, 37'd0);
    end
  endtask

  initial begin
    exp_v = '0;
    test_reset;
    test_directed;
    test_back_to_back;
    test_hold;
    test_random;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
